// File: rtl/sram_bist.sv
// Self-checking SRAM pattern tester: writes a selectable pattern over DEPTH words
// through the sram controller handshake, reads it back and compares each word.
// Optional macro SRAM_BIST_LOOP_EN: back-to-back runs while start is held, counted in pass_runs_o.
module sram_bist #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 2**18,
    parameter int ERR_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
`ifdef SRAM_BIST_LOOP_EN
    output logic [15:0]       pass_runs_o,
`endif
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] data_write_o,
    output logic              write_o,
    output logic              read_o,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_read_i
);
    // state   | meaning
    // IDLE    | waiting for first start edge
    // WR_REQ  | wait ready, issue write
    // WR_WAIT | write in flight
    // RD_REQ  | wait ready, issue read
    // RD_WAIT | read in flight, capture data on ready
    // CHECK   | compare captured word against pattern
    // DONE    | results held until next start edge
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE} state_t;

    localparam int                TW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TLOAD = TW'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] az;
        logic [DATA_W-1:0] alt;
        az = DATA_W'(a);
        for (int i = 0; i < DATA_W; i++) begin
            alt[i] = a[0] ^ (i % 2 != 0);
        end
        case (m)
            2'd0:    pattern = az;
            2'd1:    pattern = alt;
            2'd2:    pattern = ~az;
            default: pattern = '1;
        endcase
    endfunction

    state_t            state_q;
    logic              start_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;
    logic [TW-1:0]     wcnt_q;
    logic              first_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              tmo_q;
    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] ferr_q;
    logic              write_q;
    logic              read_q;

    logic [DATA_W-1:0] pat;
    logic [ERR_W-1:0]  err_d;
    logic [TW-1:0]     wcnt_d;
    logic              start_rise;
    logic              loop_go;
    logic              tmo_hit;
    logic              miss;
    logic              in_access;

    assign pat        = pattern(mode_q, addr_q);
    assign err_d      = (&err_q) ? err_q : err_q + ERR_W'(1);
    assign wcnt_d     = (wcnt_q > TW'(1)) ? wcnt_q - TW'(1) : wcnt_q;
    assign start_rise = start_i & ~start_q;
    assign miss       = (rdata_q != pat);
    assign in_access  = (state_q == WR_REQ) || (state_q == WR_WAIT) ||
                        (state_q == RD_REQ) || (state_q == RD_WAIT);
    // ready low at terminal count means the controller is stuck
    assign tmo_hit    = (TIMEOUT != 0) && (wcnt_q == TW'(1)) && !ready_i;

`ifdef SRAM_BIST_LOOP_EN
    logic        loop_q;
    logic [15:0] pass_runs_q;
    assign loop_go     = loop_q;
    assign pass_runs_o = pass_runs_q;
`else
    assign loop_go = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            mode_q  <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            wcnt_q  <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
`ifdef SRAM_BIST_LOOP_EN
            loop_q      <= 1'b0;
            pass_runs_q <= '0;
`endif
        end else begin
            start_q <= start_i;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            if (in_access && tmo_hit) begin
                state_q <= DONE;
                tmo_q   <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start_rise || loop_go) begin
                            mode_q  <= loop_go ? mode_q + 2'd1 : mode_i;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                            tmo_q   <= 1'b0;
                            err_q   <= '0;
                            ferr_q  <= '0;
                            addr_q  <= '0;
                            wcnt_q  <= TLOAD;
                            state_q <= WR_REQ;
`ifdef SRAM_BIST_LOOP_EN
                            loop_q  <= 1'b0;
`endif
                        end
                    end
                    WR_REQ: begin
                        if (ready_i) begin
                            data_q  <= pat;
                            write_q <= 1'b1;
                            first_q <= 1'b1;
                            wcnt_q  <= TLOAD;
                            state_q <= WR_WAIT;
                        end else begin
                            wcnt_q <= wcnt_d;
                        end
                    end
                    WR_WAIT: begin
                        first_q <= 1'b0;
                        if (ready_i && !first_q) begin
                            wcnt_q <= TLOAD;
                            if (addr_q == LAST) begin
                                addr_q  <= '0;
                                state_q <= RD_REQ;
                            end else begin
                                addr_q  <= addr_q + ADDR_W'(1);
                                state_q <= WR_REQ;
                            end
                        end else begin
                            wcnt_q <= wcnt_d;
                        end
                    end
                    RD_REQ: begin
                        if (ready_i) begin
                            read_q  <= 1'b1;
                            first_q <= 1'b1;
                            wcnt_q  <= TLOAD;
                            state_q <= RD_WAIT;
                        end else begin
                            wcnt_q <= wcnt_d;
                        end
                    end
                    RD_WAIT: begin
                        first_q <= 1'b0;
                        if (ready_i && !first_q) begin
                            rdata_q <= data_read_i;
                            state_q <= CHECK;
                        end else begin
                            wcnt_q <= wcnt_d;
                        end
                    end
                    CHECK: begin
                        if (miss) begin
                            err_q <= err_d;
                            if (err_q == '0) begin
                                ferr_q <= addr_q;
                            end
                        end
                        if (addr_q == LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !miss && (err_q == '0);
`ifdef SRAM_BIST_LOOP_EN
                            if (start_i && !miss && (err_q == '0)) begin
                                loop_q <= 1'b1;
                                if (pass_runs_q != '1) begin
                                    pass_runs_q <= pass_runs_q + 16'd1;
                                end
                            end
`endif
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            wcnt_q  <= TLOAD;
                            state_q <= RD_REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = tmo_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;
    assign address_o        = addr_q;
    assign data_write_o     = data_q;
    assign write_o          = write_q;
    assign read_o           = read_q;

endmodule
